// File: rtl/seg7_count_display.sv
// Sequential shift-add-3 BCD converter feeding a 4-digit multiplexed
// common-anode 7-segment scanner; digit 3 shows tcount with the decimal point lit.
module seg7_count_display #(
   parameter int REFRESH_DIV = 100000,
   parameter bit LZB         = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count,
   input  logic [1:0] tcount,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {CAPTURE, SHIFT, COMMIT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    iter_q, iter_d;
   logic [7:0]    shift_q, shift_d;
   logic [9:0]    bcd_q, bcd_d;
   logic [1:0]    tcStage_q, tcStage_d;
   logic          commit;

   logic [1:0]    dispH_q;
   logic [3:0]    dispT_q, dispO_q;
   logic [1:0]    dispTc_q;

   logic [RW-1:0] refresh_q;
   logic [1:0]    idx_q;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q;
   logic [3:0]    an_q;

   logic [3:0]    onesAdj, tensAdj;
   logic [9:0]    bcdAdj;
   logic [3:0]    digitVal;
   logic          digitBlank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // Hundreds never exceeds 2 for an 8-bit input, so it needs no +3 correction.
   always_comb begin
      onesAdj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
      tensAdj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
      bcdAdj  = {bcd_q[9:8], tensAdj, onesAdj};
   end

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      shift_d   = shift_q;
      bcd_d     = bcd_q;
      tcStage_d = tcStage_q;
      commit    = 1'b0;
      case (state_q)
         CAPTURE: begin
            shift_d   = count;
            bcd_d     = '0;
            tcStage_d = tcount;
            iter_d    = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            bcd_d   = {bcdAdj[8:0], shift_q[7]};
            shift_d = {shift_q[6:0], 1'b0};
            iter_d  = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = CAPTURE;
         end
         default: state_d = CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CAPTURE;
         iter_q    <= '0;
         shift_q   <= '0;
         bcd_q     <= '0;
         tcStage_q <= '0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         shift_q   <= shift_d;
         bcd_q     <= bcd_d;
         tcStage_q <= tcStage_d;
      end
   end

   // Display registers only move on COMMIT, so the scan never sees a half-built value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dispH_q  <= '0;
         dispT_q  <= '0;
         dispO_q  <= '0;
         dispTc_q <= '0;
      end else if (commit) begin
         dispH_q  <= bcd_q[9:8];
         dispT_q  <= bcd_q[7:4];
         dispO_q  <= bcd_q[3:0];
         dispTc_q <= tcStage_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         idx_q     <= '0;
      end else if (refresh_q == REFRESH_LAST) begin
         refresh_q <= '0;
         idx_q     <= idx_q + 2'd1;
      end else begin
         refresh_q <= refresh_q + 1'b1;
      end
   end

   always_comb begin
      digitVal   = dispO_q;
      digitBlank = 1'b0;
      case (idx_q)
         2'd0: digitVal = dispO_q;
         2'd1: begin
            digitVal   = dispT_q;
            digitBlank = LZB && (dispH_q == 2'd0) && (dispT_q == 4'd0);
         end
         2'd2: begin
            digitVal   = {2'b00, dispH_q};
            digitBlank = LZB && (dispH_q == 2'd0);
         end
         default: digitVal = {2'b00, dispTc_q};
      endcase
      seg_d = digitBlank ? 7'h7F : decode(digitVal);
   end

   // Outputs are registered, so they trail the scan index by one clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q  <= 4'b1111;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= blank ? 4'b1111 : ~(4'b0001 << idx_q);
         seg_q <= seg_d;
         dp_q  <= (idx_q != 2'd3);
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// Scoreboard bench: a decimal-arithmetic display model queues the expected an/seg/dp per
// clock for two DUTs (LZB=1 and LZB=0); a monitor pops and compares after each edge.
module tb_seg7_count_display;

   localparam int RD = 4;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       chkSeg;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] count = 8'd0;
   logic [1:0] tcount = 2'd0;
   logic       blank = 1'b0;
   logic [6:0] segL1, segL0;
   logic       dpL1, dpL0;
   logic [3:0] anL1, anL0;

   int assertCount = 0;
   int failCount   = 0;

   int kEdge   = 0;
   int dispVal = 0;
   int dispTc  = 0;
   int capVal  = 0;
   int capTc   = 0;

   exp_t qL1[$];
   exp_t qL0[$];

   logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   seg7_count_display #(.REFRESH_DIV(RD), .LZB(1'b1)) dutL1 (
      .clk(clk), .rst(rst), .count(count), .tcount(tcount), .blank(blank),
      .seg(segL1), .dp(dpL1), .an(anL1)
   );

   seg7_count_display #(.REFRESH_DIV(RD), .LZB(1'b0)) dutL0 (
      .clk(clk), .rst(rst), .count(count), .tcount(tcount), .blank(blank),
      .seg(segL0), .dp(dpL0), .an(anL0)
   );

   always #5 clk = ~clk;

   // Expected output for the upcoming edge, from the decimal digits of the committed value.
   function automatic exp_t expectOut(input bit lzb, input int idx, input logic blk);
      exp_t e;
      int h, t, o, digit;
      bit blankDigit;
      logic [3:0] one;
      one = 4'b0001;
      h = dispVal / 100;
      t = (dispVal / 10) % 10;
      o = dispVal % 10;
      blankDigit = 1'b0;
      case (idx)
         0: digit = o;
         1: begin digit = t; blankDigit = lzb && (h == 0) && (t == 0); end
         2: begin digit = h; blankDigit = lzb && (h == 0); end
         default: digit = dispTc;
      endcase
      e.an     = blk ? 4'b1111 : ~(one << idx);
      e.seg    = blankDigit ? 7'h7F : segTab[digit];
      e.dp     = (idx == 3) ? 1'b0 : 1'b1;
      e.chkSeg = !blk;
      return e;
   endfunction

   task automatic applyStimulus(input int cnt, input int tc, input logic blk, input logic rstv,
                                input int n);
      exp_t e;
      int idx;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         count  = 8'(cnt);
         tcount = 2'(tc);
         blank  = blk;
         rst    = rstv;
         if (!rstv) begin
            kEdge   = 0;
            dispVal = 0;
            dispTc  = 0;
            e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1; e.chkSeg = 1'b1;
            qL1.push_back(e);
            qL0.push_back(e);
         end else begin
            kEdge++;
            idx = ((kEdge - 1) / RD) % 4;
            qL1.push_back(expectOut(1'b1, idx, blk));
            qL0.push_back(expectOut(1'b0, idx, blk));
            // One conversion pass is 10 edges: sample on the first, publish on the tenth.
            if (kEdge % 10 == 1) begin
               capVal = cnt;
               capTc  = tc;
            end else if (kEdge % 10 == 0) begin
               dispVal = capVal;
               dispTc  = capTc;
            end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] expv);
      assertCount++;
      if (act !== expv) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, expv);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qL1.size() > 0) begin
            e = qL1.pop_front();
            checkOutput("an_lzb1", {3'b000, anL1}, {3'b000, e.an});
            checkOutput("dp_lzb1", {6'd0, dpL1}, {6'd0, e.dp});
            if (e.chkSeg) checkOutput("seg_lzb1", segL1, e.seg);
         end
         if (qL0.size() > 0) begin
            e = qL0.pop_front();
            checkOutput("an_lzb0", {3'b000, anL0}, {3'b000, e.an});
            checkOutput("dp_lzb0", {6'd0, dpL0}, {6'd0, e.dp});
            if (e.chkSeg) checkOutput("seg_lzb0", segL0, e.seg);
         end
      end
   end

   initial begin
      $display("[TB] start");
      applyStimulus(255, 2, 1'b0, 1'b0, 3);
      applyStimulus(255, 2, 1'b0, 1'b1, 45);
      applyStimulus(0, 0, 1'b0, 1'b1, 40);
      applyStimulus(7, 1, 1'b0, 1'b0, 3);
      applyStimulus(7, 1, 1'b0, 1'b1, 14);
      applyStimulus(200, 1, 1'b0, 1'b1, 30);
      applyStimulus(200, 1, 1'b1, 1'b1, 10);
      applyStimulus(200, 1, 1'b0, 1'b1, 10);
      applyStimulus(99, 3, 1'b0, 1'b1, 5);
      applyStimulus(99, 3, 1'b0, 1'b0, 2);
      applyStimulus(99, 3, 1'b0, 1'b1, 25);
      for (int b = 0; b < 40; b++) begin
         applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0),
                       int'($urandom_range(5, 40)));
      end
      repeat (2) @(posedge clk);
      #2;
      assertCount++;
      if (qL1.size() + qL0.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", qL1.size() + qL0.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
